// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: NOP encoding, default reset PC,
// fetch FSM encoding and the {pc, instr} buffer entry layout.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           push_i,
  input  fetch_entry_t                   entry_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output fetch_entry_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = nextPtr(rd_ptr_q);
      if (do_push) wr_ptr_d = nextPtr(wr_ptr_q);
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only looked at while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited memory
// requests, buffers in-order responses and discards stale ones after redirect.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  localparam int CW = $clog2(BUF_DEPTH+1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          pop, grant, rsp_ok, push;
  logic [CW:0]   inflight;
  logic [31:0]   target_pc;
  logic          unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];
  assign target_pc       = {redirect_pc[31:2], 2'b00};
  assign instr_valid     = (fifo_count != '0);
  assign pop             = instr_valid && !hold;
  assign grant           = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok          = imem_rvalid && (outstanding_q != '0);
  assign push            = rsp_ok && !redirect && (drop_cnt_q == '0);
  assign push_entry      = '{pc: rsp_pc_q, instr: imem_rdata};

  always_comb begin
    inflight = (CW+1)'(fifo_count) + (CW+1)'(outstanding_q) - (CW+1)'(pop);
    imem_req = (state_q == ST_RUN) && !redirect && (inflight < (CW+1)'(BUF_DEPTH));
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    if (grant && !rsp_ok)      outstanding_d = outstanding_q + 1'b1;
    else if (!grant && rsp_ok) outstanding_d = outstanding_q - 1'b1;

    // Everything still in flight at a redirect is stale; a same-cycle
    // response counts as already returned.
    if (redirect) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      drop_cnt_d = outstanding_q - CW'(rsp_ok);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  rsp_pc_d   = rsp_pc_q + 32'd4;
      if (rsp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
    end

    unique case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (redirect && (drop_cnt_d != '0)) state_d = ST_FLUSH;
      ST_FLUSH: if (drop_cnt_d == '0) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign imem_addr = fetch_pc_q;
  assign instr     = instr_valid ? fifo_head.instr : NOP_INSTR;
  assign instr_pc  = instr_valid ? fifo_head.pc : 32'h0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table drives hold/redirect/grant and
// a 1-cycle in-order memory model, with hand-computed expected outputs.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  typedef struct {
    logic        hold;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        memEn;
    logic        spur;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] pending[$];
  int          errors = 0;
  int          checks = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .hold        (hold),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return ~a;
  endfunction

  function automatic void addVec(input logic h, input logic r, input logic [31:0] rpc,
                                 input logic g, input logic m, input logic s,
                                 input logic er, input logic [31:0] ea,
                                 input logic ev, input logic [31:0] ep);
    vec_t v;
    v.hold = h; v.redir = r; v.rpc = rpc; v.gnt = g; v.memEn = m; v.spur = s;
    v.expReq = er; v.expAddr = ea; v.expValid = ev; v.expPc = ep;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s (row %0d): got %h, expected %h", name, row, got, exp);
    end
  endtask

  task automatic checkReset(input int tag);
    checkOutput("reset imem_req", tag, {31'b0, imem_req}, 32'd0);
    checkOutput("reset imem_addr", tag, imem_addr, 32'h0000_0000);
    checkOutput("reset instr", tag, instr, 32'h0000_0013);
    checkOutput("reset instr_pc", tag, instr_pc, 32'h0);
    checkOutput("reset instr_valid", tag, {31'b0, instr_valid}, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    hold        = v.hold;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    imem_gnt    = v.gnt;
    if (v.memEn && (pending.size() > 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = dataOf(pending.pop_front());
    end else if (v.spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic runVector(input int row, input vec_t v);
    logic [31:0] expInstr;
    applyStimulus(v);
    #1;
    expInstr = v.expValid ? dataOf(v.expPc) : 32'h0000_0013;
    checkOutput("imem_req", row, {31'b0, imem_req}, {31'b0, v.expReq});
    checkOutput("imem_addr", row, imem_addr, v.expAddr);
    checkOutput("instr_valid", row, {31'b0, instr_valid}, {31'b0, v.expValid});
    checkOutput("instr_pc", row, instr_pc, v.expPc);
    checkOutput("instr", row, instr, expInstr);
    if (imem_req && imem_gnt) pending.push_back(imem_addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    hold = 0; redirect = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;

    //      h  r  rpc           g  m  s  req addr          v  pc
    addVec(0, 0, 32'h0,        1, 1, 0, 0, 32'h0000_0000, 0, 32'h0);        // 0 IDLE
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0000, 0, 32'h0);        // 1 RUN
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0004, 0, 32'h0);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0008, 1, 32'h0);        // 3 first valid
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_000C, 1, 32'h4);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0010, 1, 32'h8);
    addVec(1, 0, 32'h0,        1, 1, 0, 0, 32'h0000_0014, 1, 32'hC);        // 6 hold x5
    addVec(1, 0, 32'h0,        1, 1, 0, 0, 32'h0000_0014, 1, 32'hC);
    addVec(1, 0, 32'h0,        1, 1, 0, 0, 32'h0000_0014, 1, 32'hC);
    addVec(1, 0, 32'h0,        1, 1, 0, 0, 32'h0000_0014, 1, 32'hC);
    addVec(1, 0, 32'h0,        1, 1, 0, 0, 32'h0000_0014, 1, 32'hC);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0014, 1, 32'hC);        // 11 release
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0018, 1, 32'h10);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_001C, 1, 32'h14);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0020, 1, 32'h18);
    addVec(0, 0, 32'h0,        1, 0, 0, 1, 32'h0000_0024, 1, 32'h1C);       // 15 memory stalls
    addVec(0, 0, 32'h0,        1, 0, 0, 0, 32'h0000_0028, 0, 32'h0);
    addVec(0, 1, 32'h0000_0103, 1, 0, 0, 0, 32'h0000_0028, 0, 32'h0);      // 17 redirect, 2 out
    addVec(0, 0, 32'h0,        1, 1, 0, 0, 32'h0000_0100, 0, 32'h0);        // 18 stale dropped
    addVec(0, 0, 32'h0,        1, 1, 0, 0, 32'h0000_0100, 0, 32'h0);        // 19 stale dropped
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0100, 0, 32'h0);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0104, 0, 32'h0);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0108, 1, 32'h100);
    addVec(0, 0, 32'h0,        1, 0, 0, 1, 32'h0000_010C, 1, 32'h104);      // 23
    addVec(0, 1, 32'h0000_0200, 1, 1, 0, 0, 32'h0000_0110, 0, 32'h0);      // 24 redirect + rvalid
    addVec(0, 1, 32'h0000_0300, 1, 0, 0, 0, 32'h0000_0200, 0, 32'h0);      // 25 redirect in FLUSH
    addVec(0, 0, 32'h0,        1, 1, 0, 0, 32'h0000_0300, 0, 32'h0);        // 26 last stale
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0300, 0, 32'h0);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0304, 0, 32'h0);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0308, 1, 32'h300);
    addVec(0, 1, 32'hFFFF_FFF8, 1, 1, 0, 0, 32'h0000_030C, 1, 32'h304);    // 30 redirect, buffer full
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'hFFFF_FFF8, 0, 32'h0);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0008, 1, 32'h0);
    addVec(0, 0, 32'h0,        0, 1, 0, 1, 32'h0000_000C, 1, 32'h4);        // 36 grant low x3
    addVec(0, 0, 32'h0,        0, 1, 0, 1, 32'h0000_000C, 1, 32'h8);
    addVec(0, 0, 32'h0,        0, 1, 1, 1, 32'h0000_000C, 0, 32'h0);        // 38 spurious rvalid
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_000C, 0, 32'h0);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0010, 0, 32'h0);
    addVec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0014, 1, 32'hC);

    #3;
    checkReset(-1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    foreach (vecs[i]) runVector(i, vecs[i]);

    // Asynchronous reset in the middle of a cycle with traffic in flight.
    #2;
    rstn = 1'b0;
    #1;
    checkReset(100);
    pending.delete();
    imem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    checkReset(101);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) runVector(200 + i, vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
